// File: rtl/mmio_output_port_if.sv
// CPU store/load bus, acknowledge button and display outputs of the memory-mapped output port.
interface mmio_output_port_if #(
    parameter int DATA_W = 16
);
    logic [15:0]       write_address;
    logic              write_enable;
    logic [31:0]       write_data;
    logic [15:0]       read_address;
    logic              read_enable;
    logic [31:0]       read_data;
    logic              ack;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              full;

    modport master (
        output write_address, write_enable, write_data, read_address, read_enable, ack,
        input  read_data, out_data, out_valid, full
    );

    modport slave (
        input  write_address, write_enable, write_data, read_address, read_enable, ack,
        output read_data, out_data, out_valid, full
    );
endinterface

// File: rtl/mmio_output_port.sv
// Memory-mapped output FIFO: CPU stores queue entries, a button edge (or, with
// OUTPORT_SIM_AUTOACK_EN defined, a fixed-delay auto-acknowledge) pops the head.
module mmio_output_port #(
    parameter logic [15:0] DATA_ADDR      = 16'h7F04,
    parameter logic [15:0] STATUS_ADDR    = 16'h7F08,
    parameter int          DATA_W         = 16,
    parameter int          DEPTH          = 4,
    parameter int          AUTOACK_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    mmio_output_port_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push_s, pop_s, push_ok_s, status_sel_s, out_valid_s, full_s;
    logic              unused_wdata_s;

    assign out_valid_s    = (count_q != {CNT_W{1'b0}});
    assign full_s         = (count_q == CNT_W'(DEPTH));
    assign push_s         = bus.write_enable && (bus.write_address == DATA_ADDR);
    // A full FIFO still accepts a store when the head leaves in the same cycle.
    assign push_ok_s      = push_s && (!full_s || pop_s);
    assign status_sel_s   = (bus.read_address == STATUS_ADDR);
    assign unused_wdata_s = ^bus.write_data[31:DATA_W];

`ifdef OUTPORT_SIM_AUTOACK_EN
    logic [7:0] auto_cnt_q, auto_cnt_d;
    logic       unused_ack_s;

    assign unused_ack_s = bus.ack;
    assign pop_s        = out_valid_s && (auto_cnt_q == 8'(AUTOACK_CYCLES - 1));

    // Auto-acknowledge delay counter, idle at zero while empty.
    always_comb begin
        auto_cnt_d = auto_cnt_q;
        if (!out_valid_s || pop_s) begin
            auto_cnt_d = 8'd0;
        end else begin
            auto_cnt_d = auto_cnt_q + 8'd1;
        end
    end

    // Auto-acknowledge counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            auto_cnt_q <= 8'd0;
        end else begin
            auto_cnt_q <= auto_cnt_d;
        end
    end
`else
    logic ack_s1_q, ack_s1_d, ack_s2_q, ack_s2_d;

    assign pop_s = ack_s1_q & ~ack_s2_q & out_valid_s;

    // Next state of the button synchronizer.
    always_comb begin
        ack_s1_d = bus.ack;
        ack_s2_d = ack_s1_q;
    end

    // Synchronizer resets high so a button held through reset yields no edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_s1_q <= 1'b1;
            ack_s2_q <= 1'b1;
        end else begin
            ack_s1_q <= ack_s1_d;
            ack_s2_q <= ack_s2_d;
        end
    end
`endif

    // FIFO next-state: storage, pointers, occupancy and sticky overflow.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = bus.write_data[DATA_W-1:0];
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A dropped store outranks the read-to-clear in the same cycle.
        if (push_s && !push_ok_s) begin
            overflow_d = 1'b1;
        end else if (bus.read_enable && status_sel_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.out_valid = out_valid_s;
    assign bus.full      = full_s;
    assign bus.out_data  = out_valid_s ? mem_q[rd_ptr_q] : {DATA_W{1'b0}};
    assign bus.read_data = status_sel_s
                         ? {24'd0, 4'(count_q), 1'b0, overflow_q, full_s, out_valid_s}
                         : 32'd0;
endmodule
